// File: rtl/ctrl_pipe_pkg.sv
// Shared constants and helpers for the decode-to-writeback control pipeline.
// Package control_itf: control word type, stage indices, register-index helpers.
package control_itf;

  localparam int CTRL_W  = 20;
  localparam int REG_W   = 5;
  localparam int EX_STG  = 0;
  localparam int MEM_STG = 1;
  localparam int WB_STG  = 2;

  typedef logic [CTRL_W-1:0] ctrl_word;

  // True when a non-zero destination feeds either source operand.
  function automatic logic raw_match(input logic [REG_W-1:0] rd,
                                     input logic [REG_W-1:0] rs1,
                                     input logic [REG_W-1:0] rs2);
    return (rd != '0) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/ctrl_pipe_if.sv
// Decode-side handshake into ctrl_pipe: decoded instruction fields plus in_ready.
// master drives the instruction, slave (the pipe) answers with in_ready.
interface ctrl_pipe_if
  import control_itf::*;
#(
  parameter int WIDTH = CTRL_W
);
  logic             in_valid;
  logic [WIDTH-1:0] in_ctrl;
  logic [REG_W-1:0] in_rd;
  logic [REG_W-1:0] in_rs1;
  logic [REG_W-1:0] in_rs2;
  logic             in_ld_reg;
  logic             in_mem_rd;
  logic             in_ready;

  modport master (
    output in_valid, in_ctrl, in_rd, in_rs1, in_rs2, in_ld_reg, in_mem_rd,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_ctrl, in_rd, in_rs1, in_rs2, in_ld_reg, in_mem_rd,
    output in_ready
  );
endinterface

// File: rtl/ctrl_stage_reg.sv
// One control-pipeline stage: valid, control word, rd, ld_reg and mem_rd.
// Hold keeps every field; flush clears valid only and wins over hold and load.
module ctrl_stage_reg
  import control_itf::*;
#(
  parameter int WIDTH = CTRL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             flush,
  input  logic             d_valid,
  input  logic [WIDTH-1:0] d_ctrl,
  input  logic [REG_W-1:0] d_rd,
  input  logic             d_ld_reg,
  input  logic             d_mem_rd,
  output logic             q_valid,
  output logic [WIDTH-1:0] q_ctrl,
  output logic [REG_W-1:0] q_rd,
  output logic             q_ld_reg,
  output logic             q_mem_rd
);

  logic             valid_reg;
  logic [WIDTH-1:0] ctrl_reg;
  logic [REG_W-1:0] rd_reg;
  logic             ld_reg_reg;
  logic             mem_rd_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg  <= 1'b0;
      ctrl_reg   <= '0;
      rd_reg     <= '0;
      ld_reg_reg <= 1'b0;
      mem_rd_reg <= 1'b0;
    end else begin
      if (flush) begin
        valid_reg <= 1'b0;
      end else if (!hold) begin
        valid_reg <= d_valid;
      end
      // Payload of a bubble or flushed slot is don't-care, so it simply follows the load.
      if (!hold) begin
        ctrl_reg   <= d_ctrl;
        rd_reg     <= d_rd;
        ld_reg_reg <= d_ld_reg;
        mem_rd_reg <= d_mem_rd;
      end
    end
  end

  assign q_valid  = valid_reg;
  assign q_ctrl   = ctrl_reg;
  assign q_rd     = rd_reg;
  assign q_ld_reg = ld_reg_reg;
  assign q_mem_rd = mem_rd_reg;

endmodule

// File: rtl/ctrl_pipe.sv
// Control-word pipeline after decode with stall/flush and load-use interlock.
// Define CTRL_PIPE_PERF_EN to build the saturating load-use bubble counter.
module ctrl_pipe
  import control_itf::*;
#(
  parameter int STAGES = 3,
  parameter int WIDTH  = CTRL_W,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  ctrl_pipe_if.slave                bus,
  input  logic [STAGES-1:0]         stall,
  input  logic [STAGES-1:0]         flush,
  output logic [STAGES-1:0]         stage_valid,
  output logic [STAGES*WIDTH-1:0]   stage_ctrl,
  output logic [REG_W*STAGES-1:0]   stage_rd,
  output logic [STAGES-1:0]         stage_wb_en,
  output logic                      lu_hazard,
  output logic [CNT_W-1:0]          bubble_cnt
);

  logic [STAGES-1:0] hold;
  logic [STAGES-1:0] d_valid;
  logic [STAGES-1:0] d_ld_reg;
  logic [STAGES-1:0] d_mem_rd;
  logic [WIDTH-1:0]  d_ctrl [STAGES];
  logic [REG_W-1:0]  d_rd   [STAGES];
  logic [WIDTH-1:0]  q_ctrl [STAGES];
  logic [REG_W-1:0]  q_rd   [STAGES];
  logic [STAGES-1:0] q_ld_reg;
  logic [STAGES-1:0] q_mem_rd;
  logic              in_ready;
  logic              unused_last_mem_rd;

  // A stall at stage k also freezes everything younger, so hold is a suffix OR.
  assign hold[STAGES-1] = stall[STAGES-1];
  genvar gi;
  generate
    for (gi = 0; gi < STAGES-1; gi++) begin : g_hold
      assign hold[gi] = stall[gi] | hold[gi+1];
    end
  endgenerate

  assign lu_hazard = bus.in_valid & stage_valid[EX_STG] & q_mem_rd[EX_STG] &
                     q_ld_reg[EX_STG] & raw_match(q_rd[EX_STG], bus.in_rs1, bus.in_rs2);
  assign in_ready     = ~hold[0] & ~lu_hazard;
  assign bus.in_ready = in_ready;

  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign d_valid[gi]  = bus.in_valid & in_ready;
        assign d_ctrl[gi]   = bus.in_ctrl;
        assign d_rd[gi]     = bus.in_rd;
        assign d_ld_reg[gi] = bus.in_ld_reg;
        assign d_mem_rd[gi] = bus.in_mem_rd;
      end else begin : g_body
        // An older stage moving away from a held younger one receives a bubble.
        assign d_valid[gi]  = stage_valid[gi-1] & ~hold[gi-1];
        assign d_ctrl[gi]   = q_ctrl[gi-1];
        assign d_rd[gi]     = q_rd[gi-1];
        assign d_ld_reg[gi] = q_ld_reg[gi-1];
        assign d_mem_rd[gi] = q_mem_rd[gi-1];
      end

      ctrl_stage_reg #(.WIDTH(WIDTH)) u_stage (
        .clk      (clk),
        .rst      (rst),
        .hold     (hold[gi]),
        .flush    (flush[gi]),
        .d_valid  (d_valid[gi]),
        .d_ctrl   (d_ctrl[gi]),
        .d_rd     (d_rd[gi]),
        .d_ld_reg (d_ld_reg[gi]),
        .d_mem_rd (d_mem_rd[gi]),
        .q_valid  (stage_valid[gi]),
        .q_ctrl   (q_ctrl[gi]),
        .q_rd     (q_rd[gi]),
        .q_ld_reg (q_ld_reg[gi]),
        .q_mem_rd (q_mem_rd[gi])
      );

      assign stage_ctrl[gi*WIDTH +: WIDTH] = q_ctrl[gi];
      assign stage_rd[gi*REG_W +: REG_W]   = q_rd[gi];
      assign stage_wb_en[gi] = stage_valid[gi] & q_ld_reg[gi] & (q_rd[gi] != '0);
    end
  endgenerate

  // The oldest stage's mem_rd has no consumer once the word retires.
  assign unused_last_mem_rd = q_mem_rd[STAGES-1];

`ifdef CTRL_PIPE_PERF_EN
  logic [CNT_W-1:0] bubble_cnt_reg;

  // Only hazard bubbles that actually enter stage 0 are counted; a held stage 0 inserts none.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_reg <= '0;
    end else if (!hold[0] && lu_hazard && (bubble_cnt_reg != '1)) begin
      bubble_cnt_reg <= bubble_cnt_reg + 1'b1;
    end
  end

  assign bubble_cnt = bubble_cnt_reg;
`else
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: directed scenarios then random traffic,
// compared each cycle against a stage-array reference model.
module tb_ctrl_pipe;
  import control_itf::*;

  localparam int NS = 3;
  localparam int W  = CTRL_W;
  localparam int CW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NS-1:0]     stall;
  logic [NS-1:0]     flush;
  logic [NS-1:0]     stage_valid;
  logic [NS*W-1:0]   stage_ctrl;
  logic [5*NS-1:0]   stage_rd;
  logic [NS-1:0]     stage_wb_en;
  logic              lu_hazard;
  logic [CW-1:0]     bubble_cnt;

  ctrl_pipe_if #(.WIDTH(W)) bus ();

  ctrl_pipe #(.STAGES(NS), .WIDTH(W), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .stall       (stall),
    .flush       (flush),
    .stage_valid (stage_valid),
    .stage_ctrl  (stage_ctrl),
    .stage_rd    (stage_rd),
    .stage_wb_en (stage_wb_en),
    .lu_hazard   (lu_hazard),
    .bubble_cnt  (bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         v;
    logic [W-1:0] c;
    logic [4:0]   rd;
    logic         ld;
    logic         mr;
  } ent_t;

  ent_t m [NS];
  int   exp_cnt;
  int   n_cmp = 0;
  int   n_err = 0;

  // stimulus held by the bench
  logic          v_in, ld_in, mr_in, r_in;
  logic [W-1:0]  c_in;
  logic [4:0]    rd_in, rs1_in, rs2_in;
  logic [NS-1:0] st_in, fl_in;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic bit m_hold(input int k);
    for (int j = k; j < NS; j++) if (st_in[j]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_haz();
    return v_in && m[0].v && m[0].mr && m[0].ld && (m[0].rd != 0) &&
           ((m[0].rd == rs1_in) || (m[0].rd == rs2_in));
  endfunction

  task automatic drive();
    bus.in_valid  = v_in;
    bus.in_ctrl   = c_in;
    bus.in_rd     = rd_in;
    bus.in_rs1    = rs1_in;
    bus.in_rs2    = rs2_in;
    bus.in_ld_reg = ld_in;
    bus.in_mem_rd = mr_in;
    stall         = st_in;
    flush         = fl_in;
    rst           = r_in;
  endtask

  task automatic model_step();
    ent_t n [NS];
    bit hz, rdy;
    hz  = m_haz();
    rdy = !m_hold(0) && !hz;
    if (r_in) begin
      for (int k = 0; k < NS; k++) n[k] = '0;
      exp_cnt = 0;
    end else begin
`ifdef CTRL_PIPE_PERF_EN
      if (!m_hold(0) && hz && exp_cnt < (1 << CW) - 1) exp_cnt++;
`endif
      for (int k = 0; k < NS; k++) begin
        n[k] = m[k];
        if (fl_in[k]) n[k].v = 1'b0;
        else if (m_hold(k)) n[k] = m[k];
        else if (k == 0) begin
          n[0].v  = v_in && rdy;
          n[0].c  = c_in;
          n[0].rd = rd_in;
          n[0].ld = ld_in;
          n[0].mr = mr_in;
        end else if (m_hold(k-1)) n[k].v = 1'b0;
        else n[k] = m[k-1];
      end
    end
    for (int k = 0; k < NS; k++) m[k] = n[k];
  endtask

  task automatic check_state();
    logic [NS-1:0] ev, ew;
    for (int k = 0; k < NS; k++) begin
      ev[k] = m[k].v;
      ew[k] = m[k].v && m[k].ld && (m[k].rd != 0);
      if (m[k].v) begin
        chk($sformatf("stage%0d_ctrl", k), stage_ctrl[k*W +: W], m[k].c);
        chk($sformatf("stage%0d_rd", k), stage_rd[k*5 +: 5], m[k].rd);
      end
    end
    chk("stage_valid", stage_valid, ev);
    chk("stage_wb_en", stage_wb_en, ew);
    chk("bubble_cnt", bubble_cnt, exp_cnt);
  endtask

  task automatic tick();
    drive();
    #1;
    chk("lu_hazard", lu_hazard, m_haz());
    chk("in_ready", bus.in_ready, !m_hold(0) && !m_haz());
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_state();
    $display("cyc v=%0b c=%05h rd=%0d rs=%0d/%0d st=%b fl=%b rst=%0b -> valid=%b haz=%0b cnt=%0d",
             v_in, c_in, rd_in, rs1_in, rs2_in, st_in, fl_in, r_in, stage_valid, lu_hazard, bubble_cnt);
  endtask

  task automatic idle();
    v_in = 0; c_in = '0; rd_in = 0; rs1_in = 0; rs2_in = 0;
    ld_in = 0; mr_in = 0; st_in = '0; fl_in = '0; r_in = 0;
  endtask

  task automatic word(input logic [W-1:0] c, input logic [4:0] rd, input logic ld, input logic mr,
                      input logic [4:0] rs1, input logic [4:0] rs2);
    v_in = 1; c_in = c; rd_in = rd; ld_in = ld; mr_in = mr; rs1_in = rs1; rs2_in = rs2;
  endtask

  initial begin
    idle();
    r_in = 1;
    drive();
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NS; k++) m[k] = '0;
    exp_cnt = 0;

    // reset state
    tick();
    chk("rst_ctrl", stage_ctrl, 0);
    chk("rst_rd", stage_rd, 0);
    idle();

    // single word traverses EX -> MEM -> WB
    word(20'h0ABCD, 5'd5, 1, 0, 0, 0);
    tick();
    chk("trav_c1", stage_valid, 3'b001);
    idle();
    tick();
    chk("trav_c2", stage_valid, 3'b010);
    tick();
    chk("trav_c3", stage_valid, 3'b100);
    chk("trav_wb_ctrl", stage_ctrl[WB_STG*W +: W], 20'h0ABCD);
    tick();

    // load-use hazard inserts one bubble
    word(20'h11111, 5'd7, 1, 1, 0, 0);
    tick();
    word(20'h22222, 5'd9, 0, 0, 5'd7, 0);
    drive();
    #1;
    chk("lu_flag", lu_hazard, 1'b1);
    chk("lu_ready", bus.in_ready, 1'b0);
    tick();
    chk("lu_bubble_s0", stage_valid[0], 1'b0);
    chk("lu_load_s1", stage_rd[5 +: 5], 5'd7);
    tick();
    // a load to x0 never interlocks
    word(20'h33333, 5'd0, 1, 1, 0, 0);
    tick();
    word(20'h44444, 5'd2, 0, 0, 5'd0, 5'd0);
    drive();
    #1;
    chk("lu_x0", lu_hazard, 1'b0);
    tick();
    idle();
    repeat (3) tick();

    // stall middle stage for two cycles with A,B,C in flight
    word(20'h0000C, 5'd3, 1, 0, 0, 0); tick();
    word(20'h0000B, 5'd2, 1, 0, 0, 0); tick();
    word(20'h0000A, 5'd1, 1, 0, 0, 0); tick();
    word(20'h0000D, 5'd4, 1, 0, 0, 0);
    st_in = 3'b010;
    tick();
    chk("stall_c1", stage_valid, 3'b011);
    tick();
    chk("stall_c2", stage_valid, 3'b011);
    st_in = '0;
    tick();
    idle();
    repeat (4) tick();

    // flush EX/MEM while EX is stalled
    word(20'h00001, 5'd1, 1, 0, 0, 0); tick();
    word(20'h00002, 5'd2, 1, 0, 0, 0); tick();
    word(20'h00003, 5'd3, 1, 0, 0, 0); tick();
    idle();
    fl_in = 3'b011; st_in = 3'b001;
    tick();
    chk("flush_s01", stage_valid[1:0], 2'b00);
    chk("flush_s2", stage_valid[2], 1'b1);
    idle();
    tick();

    // reset mid-stream overrides a full stall
    word(20'h00055, 5'd5, 1, 1, 0, 0); tick();
    word(20'h00066, 5'd6, 1, 0, 5'd5, 0); tick();
    tick();
    r_in = 1; st_in = 3'b111;
    tick();
    chk("rst_mid_valid", stage_valid, 3'b000);
    chk("rst_mid_cnt", bubble_cnt, 0);
    idle();
    tick();

    // twenty hazard bubbles saturate a 4-bit counter
    for (int i = 0; i < 20; i++) begin
      word(W'($urandom), 5'd3, 1, 1, 0, 0);
      tick();
      word(W'($urandom), 5'd4, 0, 0, 0, 5'd3);
      tick();
      tick();
    end
`ifdef CTRL_PIPE_PERF_EN
    chk("bubble_sat", bubble_cnt, 4'hF);
`else
    chk("bubble_off", bubble_cnt, 4'h0);
`endif
    idle();
    tick();

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      v_in   = ($urandom % 4) != 0;
      c_in   = W'($urandom);
      rd_in  = 5'($urandom % 4);
      rs1_in = 5'($urandom % 4);
      rs2_in = 5'($urandom % 4);
      ld_in  = 1'($urandom);
      mr_in  = 1'($urandom);
      st_in  = (($urandom % 4) == 0) ? NS'($urandom) : '0;
      fl_in  = (($urandom % 6) == 0) ? NS'($urandom) : '0;
      r_in   = (($urandom % 60) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 SHALL have parameter STAGES, default 3, number of control-word stages after decode (0=EX, 1=MEM, 2=WB); legal range 2..6.
REQ-002 SHALL have parameter WIDTH, default 20, opaque control-word width in bits.
REQ-003 SHALL have parameter CNT_W, default 16, bubble-counter width.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  1  decoded instruction present at input.
REQ-007 in_ctrl  in  WIDTH  decoded control word.
REQ-008 in_rd / in_rs1 / in_rs2  in  5 each  destination and source register indices.
REQ-009 in_ld_reg  in  1  instruction writes regfile; in_mem_rd  in  1  instruction reads dcache.
REQ-010 in_ready  out  1  input accepted this cycle when in_valid and in_ready are both high.
REQ-011 stall  in  STAGES  stall[k] holds stage k and all younger stages.
REQ-012 flush  in  STAGES  flush[k] invalidates stage k at next edge.
REQ-013 stage_valid  out  STAGES  per-stage valid.
REQ-014 stage_ctrl  out  STAGES*WIDTH  stage k word at bits [k*WIDTH +: WIDTH].
REQ-015 stage_rd  out  5*STAGES  per-stage rd; stage_wb_en  out  STAGES  valid AND ld_reg AND rd!=0.
REQ-016 lu_hazard  out  1  combinational load-use hazard flag.
REQ-017 bubble_cnt  out  CNT_W  load-use bubbles inserted (see Configuration).

Function
REQ-018 hold_k SHALL equal OR of stall[j] for j>=k.
REQ-019 lu_hazard SHALL be in_valid & valid_0 & mem_rd_0 & ld_reg_0 & (rd_0!=0) & (rd_0==in_rs1 | rd_0==in_rs2).
REQ-020 in_ready SHALL be !hold_0 & !lu_hazard, combinational, no registered latency.
REQ-021 Stage 0, not held: SHALL load the input (valid=in_valid) when in_ready, else load a bubble (valid=0).
REQ-022 Stage k>0, not held: SHALL load stage k-1 contents in one cycle.
REQ-023 Held stage SHALL keep all fields unchanged.
REQ-024 Stage k not held while stage k-1 held SHALL load a bubble.
REQ-025 flush[k] SHALL force valid_k=0 at next edge, overriding hold and load; ctrl/rd contents don't-care.
REQ-026 A word SHALL traverse stage 0 to stage STAGES-1 in STAGES-1 cycles when no stall/flush.
REQ-027 Simultaneous lu_hazard and hold_0: hold wins, stage 0 unchanged, no bubble counted.
REQ-028 Stage STAGES-1 SHALL retire (be overwritten) every cycle it is not held.

Reset
REQ-029 On rst: all stage_valid=0, all ctrl=0, rd=0, ld_reg=0, mem_rd=0, bubble_cnt=0; next edge after rst deasserts SHALL accept input.
REQ-030 rst SHALL override stall and flush; in-flight words are discarded.

Configuration
REQ-031 Macro CTRL_PIPE_PERF_EN defined: bubble_cnt SHALL increment by 1 each cycle stage 0 loads a bubble because of lu_hazard, saturating at all-ones.
REQ-032 Macro undefined: bubble_cnt port SHALL remain and be tied to 0, no counter flops.

Structure
REQ-033 CTRL_W (=20) and stage index constants (EX_STG=0, MEM_STG=1, WB_STG=2) SHALL reside in package control_itf alongside ctrl_word.
REQ-034 One sub-module ctrl_stage_reg SHALL implement one stage (valid, ctrl, rd, ld_reg, mem_rd with load/hold/bubble/flush), instantiated STAGES times via generate.

Verification
REQ-035 Reset then in_valid=1, in_ctrl=20'h0ABCD, rd=5, no stall -> stage_valid=3'b001,3'b010,3'b100 on cycles 1,2,3; stage_ctrl WB slice=20'h0ABCD.
REQ-036 Load rd=7 in stage 0, input rs1=7 -> lu_hazard=1, in_ready=0, next cycle stage 0 valid=0, load in stage 1, bubble_cnt=1 (PERF_EN); rd=0 load -> no hazard.
REQ-037 stall=3'b010 for 2 cycles with words A,B,C in stages 0..2 -> A,B held, stage 2 bubble then bubble, in_ready=0; release -> flow resumes, nothing lost or duplicated.
REQ-038 flush=3'b011 with stall=3'b001 same cycle -> stages 0,1 valid=0 next edge, stage 2 unaffected.
REQ-039 rst asserted mid-stream with stall=3'b111 -> all valid=0 next edge, bubble_cnt=0.
REQ-040 CNT_W=4, 20 consecutive hazard bubbles -> bubble_cnt saturates at 4'hF; build without CTRL_PIPE_PERF_EN -> bubble_cnt stays 0.
